learn_mode_scorer: RTL
======================

# learn_mode_scorer

Parametrised learn-mode engine for the electronic organ. It consumes expected notes from the song FIFO (first-word-fall-through) and waits for the player to press the matching key chord and octave. It scores every note as a hit, a miss (timeout) or a wrong press, and tracks the current and best streak. It sits between the song FIFO and the display/LED driver, which shows `exp_keys`/`exp_oct` as guidance and the counters as score.

## Interface
Parameters:
- `KEYS`, 8, number of note keys.
- `OCT_W`, 2, octave field width.
- `TIMEOUT_CYC`, 100_000_000, cycles allowed per note; 0 disables the timeout.
- `CNT_W`, 8, width of all score counters.

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: reset; asynchronous, active-low.
- `enable` in 1: learn mode selected; low forces IDLE.
- `clear` in 1: synchronous clear of all counters and streaks.
- `buts` in KEYS: debounced key levels, with bit i = key i.
- `octave` in OCT_W: current octave selection.
- `note_data` in KEYS+OCT_W: FIFO head.
  - Bit (KEYS+OCT_W-1-i) = key i, so key 0 is the MSB.
  - Low OCT_W bits = octave.
- `note_valid` in 1: FIFO not empty; `note_data` is valid.
- `song_end` in 1: no further notes will arrive.
- `note_pop` out 1: consumes the FIFO head this cycle.
- `exp_keys` out KEYS: latched expected keys, in `buts` bit order.
- `exp_oct` out OCT_W: latched expected octave.
- `hit` / `miss` / `wrong` out 1: one-cycle event pulses.
- `hit_cnt`, `miss_cnt`, `wrong_cnt` out CNT_W: saturating counts.
- `streak`, `best_streak` out CNT_W: saturating streak counters.
- `done` out 1: song finished.

## Operation
Input sampling:
- `buts` and `octave` are registered once into `buts_q`/`oct_q`. All compares use the registered copies.
- `match` = (`buts_q` == `exp_keys`) and (`oct_q` == `exp_oct`).

States:
- IDLE:
  - Go to FETCH when `enable`=1.
- FETCH:
  - If `note_valid`: `note_pop`=1 (combinational, one cycle), and `exp_*` load from `note_data` on the same edge, with key bits reversed into `buts` order.
  - If the loaded keys are all zero, the note is a rest: stay in FETCH, no scoring.
  - If the loaded keys are non-zero: go to WAIT_KEY and clear the timer.
  - If `!note_valid` and `song_end`: go to DONE.
  - Otherwise wait in FETCH.
- WAIT_KEY:
  - Timer increments each cycle.
  - If `match`: `hit` pulse, `hit_cnt`++, `streak`++, `best_streak` = max(`best_streak`, new `streak`); go to RELEASE.
  - Else, if the timer reaches TIMEOUT_CYC-1: `miss` pulse, `miss_cnt`++, `streak`=0; go to RELEASE.
  - Else, if any key rises in `buts_q` (0→1 vs the previous `buts_q`) that is not in `exp_keys`: `wrong` pulse, `wrong_cnt`++, `streak`=0; stay in WAIT_KEY, timer not reset.
  - `match` has priority over timeout and wrong press in the same cycle.
- RELEASE:
  - Wait until `buts_q`==0, then go to FETCH.
  - This stops a held chord from scoring consecutive identical notes.
- DONE:
  - `done`=1, outputs held.
  - Go to IDLE when `enable`=0.

Global rules:
- `enable`=0 in any state: IDLE next edge. Counters and `exp_*` are held; a pending note is dropped without scoring.
- `clear`=1: counters and streaks go to 0 next edge, in any state. It overrides any same-cycle increment. The FSM is unaffected.
- Counters saturate at 2^CNT_W-1 and never wrap.
- `note_pop` is asserted only in FETCH with `note_valid`=1. It is never asserted while `note_valid`=0.

## Timing
- Reset values:
  - State = IDLE.
  - All counters, streaks, `exp_*`, `buts_q`, `oct_q` = 0.
  - `hit`/`miss`/`wrong`/`done`/`note_pop` = 0.
- Reset mid-song: immediately IDLE with all values zeroed. The FIFO is not popped during reset.
- Latency:
  - `buts` stable at edge N → `buts_q` at N+1 → `hit` registered, high in cycle N+2 to N+3.
  - Enable to first pop: `enable` seen at edge E → FETCH at E+1 → `note_pop` during cycle E+1 if `note_valid`.
- Timeout: `miss` rises exactly TIMEOUT_CYC cycles after WAIT_KEY entry, provided there is no match.
- Event pulses are exactly one cycle wide. At most one of `hit`/`miss` per note.
- Back-to-back notes: the minimum spacing between pops is 3 cycles (FETCH→WAIT_KEY→RELEASE→FETCH) with instant release.

## Test plan
- Reset, `enable`=1, FIFO head `note_data`=10'b1000_0000_01 (key 0, octave 1), then drive `buts`=8'h01, `octave`=1 → exactly one `note_pop`, `exp_keys`=8'h01, `hit` 2 cycles after `buts` changes, `hit_cnt`=1, `streak`=1.
- TIMEOUT_CYC=16, expected key 3, no keys pressed → `miss` exactly 16 cycles after WAIT_KEY entry, `miss_cnt`=1, `streak`=0, then FETCH.
- Expected key 2, press key 5, then keys 2 and 5 together, then key 2 alone → `wrong` once, no `hit` on 2+5, `hit` on key 2 alone, `streak` reset then 1.
- Two identical notes (key 4); hold key 4 throughout → only one `hit` until `buts`=0, then the second `hit` on re-press.
- Rest note (keys=0), then key 1 note; `song_end`=1 after the FIFO empties → rest popped with no event, key 1 hit, then `done`=1; `enable`=0 → IDLE, `done`=0.
- CNT_W=2, 5 consecutive hits, then `clear` on the same cycle as a hit → `hit_cnt` saturates at 3, `best_streak`=3, clear wins (all 0). Assert `rst_n` low mid-WAIT_KEY → outputs zero asynchronously, no pop.

Source files
------------

// File: rtl/learn_mode_scorer.sv
// Learn-mode engine: pulls expected notes from the song FIFO, waits for the matching
// chord/octave and scores each note as hit, miss (timeout) or wrong press.
module learn_mode_scorer #(
  parameter int KEYS        = 8,
  parameter int OCT_W       = 2,
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [KEYS-1:0]       buts,
  input  logic [OCT_W-1:0]      octave,
  input  logic [KEYS+OCT_W-1:0] note_data,
  input  logic                  note_valid,
  input  logic                  song_end,
  output logic                  note_pop,
  output logic [KEYS-1:0]       exp_keys,
  output logic [OCT_W-1:0]      exp_oct,
  output logic                  hit,
  output logic                  miss,
  output logic                  wrong,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt,
  output logic [CNT_W-1:0]      wrong_cnt,
  output logic [CNT_W-1:0]      streak,
  output logic [CNT_W-1:0]      best_streak,
  output logic                  done
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_KEY, RELEASE, DONE} state_t;

  state_t           state;
  logic [KEYS-1:0]  buts_q, buts_prev, note_keys;
  logic [OCT_W-1:0] oct_q;
  logic [TMR_W-1:0] timer;
  logic             match, timeout, wrong_press;
  logic [CNT_W-1:0] streak_inc;

  // FIFO words carry key 0 in the MSB; flip into buts order
  for (genvar i = 0; i < KEYS; i++) begin : g_rev
    assign note_keys[i] = note_data[KEYS+OCT_W-1-i];
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign match       = (buts_q == exp_keys) && (oct_q == exp_oct);
  assign timeout     = (TIMEOUT_CYC != 0) && (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign wrong_press = |(buts_q & ~buts_prev & ~exp_keys);
  assign streak_inc  = sat_inc(streak);
  assign note_pop    = enable && (state == FETCH) && note_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      buts_q      <= '0;
      buts_prev   <= '0;
      oct_q       <= '0;
      timer       <= '0;
      exp_keys    <= '0;
      exp_oct     <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      wrong       <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      wrong_cnt   <= '0;
      streak      <= '0;
      best_streak <= '0;
      done        <= 1'b0;
    end else begin
      buts_q    <= buts;
      buts_prev <= buts_q;
      oct_q     <= octave;
      hit       <= 1'b0;
      miss      <= 1'b0;
      wrong     <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= FETCH;
          FETCH: begin
            if (note_valid) begin
              exp_keys <= note_keys;
              exp_oct  <= note_data[OCT_W-1:0];
              // all-zero keys is a rest: consumed silently, keep fetching
              if (|note_keys) begin
                state <= WAIT_KEY;
                timer <= '0;
              end
            end else if (song_end) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          WAIT_KEY: begin
            timer <= timer + TMR_W'(1);
            if (match) begin
              hit     <= 1'b1;
              hit_cnt <= sat_inc(hit_cnt);
              streak  <= streak_inc;
              if (streak_inc > best_streak) best_streak <= streak_inc;
              state   <= RELEASE;
            end else if (timeout) begin
              miss     <= 1'b1;
              miss_cnt <= sat_inc(miss_cnt);
              streak   <= '0;
              state    <= RELEASE;
            end else if (wrong_press) begin
              wrong     <= 1'b1;
              wrong_cnt <= sat_inc(wrong_cnt);
              streak    <= '0;
            end
          end
          // a held chord must be let go before the next note can score
          RELEASE: if (buts_q == '0) state <= FETCH;
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
      if (clear) begin
        hit_cnt     <= '0;
        miss_cnt    <= '0;
        wrong_cnt   <= '0;
        streak      <= '0;
        best_streak <= '0;
      end
    end
  end

endmodule
